// File: rtl/run_sequencer.sv
// Run controller for the 8-bit core: handles the req/done handshake, holds the core in reset,
// loads the program start address, counts RUN cycles and aborts runaway programs on timeout.
module run_sequencer #(
    parameter int unsigned D         = 12,
    parameter int unsigned CW        = 16,
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned DRAIN_CYC = 1,
    parameter int unsigned TIMEOUT   = 4000,
    parameter int unsigned STRIDE    = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [1:0]    prog_sel,
    input  logic          halt_in,
    output logic          core_rst,
    output logic          core_en,
    output logic [D-1:0]  start_addr,
    output logic          done,
    output logic          err_tmo,
    output logic [CW-1:0] cycle_cnt
);

    localparam int unsigned CCW = (CLR_CYC > 1)   ? $clog2(CLR_CYC)   : 1;
    localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t         state, state_n;
    logic [CCW-1:0] clr_cnt, clr_cnt_n;
    logic [DCW-1:0] drain_cnt, drain_cnt_n;
    logic [CW-1:0]  cycle_cnt_n, cnt_inc;
    logic           err_tmo_n;
    logic [D-1:0]   start_addr_n;
    logic [31:0]    addr_prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            drain_cnt  <= '0;
            cycle_cnt  <= '0;
            err_tmo    <= 1'b0;
            start_addr <= '0;
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_cnt_n;
            drain_cnt  <= drain_cnt_n;
            cycle_cnt  <= cycle_cnt_n;
            err_tmo    <= err_tmo_n;
            start_addr <= start_addr_n;
        end
    end

    always_comb begin
        state_n      = state;
        clr_cnt_n    = clr_cnt;
        drain_cnt_n  = drain_cnt;
        cycle_cnt_n  = cycle_cnt;
        err_tmo_n    = err_tmo;
        start_addr_n = start_addr;
        cnt_inc      = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;
        addr_prod    = {30'd0, prog_sel} * STRIDE;

        core_rst = (state == IDLE) || (state == CLEAR);
        core_en  = (state == RUN);
        done     = (state == DONE);

        case (state)
            IDLE: begin
                if (req) begin
                    state_n      = CLEAR;
                    start_addr_n = addr_prod[D-1:0];
                    cycle_cnt_n  = '0;
                    err_tmo_n    = 1'b0;
                    clr_cnt_n    = '0;
                end
            end
            CLEAR: begin
                if (!req)                              state_n = IDLE;
                else if (clr_cnt == CCW'(CLR_CYC - 1)) state_n = RUN;
                else                                   clr_cnt_n = clr_cnt + 1'b1;
            end
            RUN: begin
                // The count is compared after increment, so TIMEOUT equals the number of RUN cycles.
                cycle_cnt_n = cnt_inc;
                if (!req) begin
                    state_n = IDLE;
                end else if (halt_in) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                    err_tmo_n   = 1'b1;
                end
            end
            DRAIN: begin
                if (!req)                                  state_n = IDLE;
                else if (drain_cnt == DCW'(DRAIN_CYC - 1)) state_n = DONE;
                else                                       drain_cnt_n = drain_cnt + 1'b1;
            end
            DONE: begin
                if (!req) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Table-driven bench for run_sequencer: each row applies inputs, waits one edge and compares
// all outputs against hand-computed values; async reset is checked by a hand-written sequence.
module tb_run_sequencer;

    logic        clk;
    logic        reset;
    logic        req;
    logic [1:0]  prog_sel;
    logic        halt_in;
    logic        core_rst;
    logic        core_en;
    logic [11:0] start_addr;
    logic        done;
    logic        err_tmo;
    logic [15:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req;
        logic [1:0]  sel;
        logic        halt;
        logic        rst;
        logic        en;
        logic        dn;
        logic        tmo;
        logic [15:0] cnt;
        logic [11:0] addr;
    } vec_t;

    vec_t vecs[$];

    run_sequencer #(
        .D(12), .CW(16), .CLR_CYC(2), .DRAIN_CYC(1), .TIMEOUT(20), .STRIDE(256)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .halt_in(halt_in),
        .core_rst(core_rst), .core_en(core_en), .start_addr(start_addr),
        .done(done), .err_tmo(err_tmo), .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int r, input int s, input int h, input int er, input int ee,
                       input int ed, input int et, input int c, input int a);
        vec_t v;
        v.req  = r[0];
        v.sel  = s[1:0];
        v.halt = h[0];
        v.rst  = er[0];
        v.en   = ee[0];
        v.dn   = ed[0];
        v.tmo  = et[0];
        v.cnt  = c[15:0];
        v.addr = a[11:0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input int er, input int ee, input int ed, input int et,
                           input int c, input int a);
        chk("core_rst",   idx, 32'(core_rst),   32'(er));
        chk("core_en",    idx, 32'(core_en),    32'(ee));
        chk("done",       idx, 32'(done),       32'(ed));
        chk("err_tmo",    idx, 32'(err_tmo),    32'(et));
        chk("cycle_cnt",  idx, 32'(cycle_cnt),  32'(c));
        chk("start_addr", idx, 32'(start_addr), 32'(a));
    endtask

    initial begin
        // basic run, halt on RUN cycle 10; halt/prog_sel ignored in IDLE and CLEAR
        add(1,1,1, 1,0,0,0, 0,256);
        add(1,2,1, 1,0,0,0, 0,256);
        add(1,2,0, 0,1,0,0, 0,256);
        for (int i = 1; i <= 9; i++) add(1,0,0, 0,1,0,0, i,256);
        add(1,0,1, 0,0,0,0, 10,256);
        add(1,0,0, 0,0,1,0, 10,256);
        // handshake: req held high keeps DONE, then drop and restart with prog_sel=3
        for (int i = 0; i < 10; i++) add(1,0,0, 0,0,1,0, 10,256);
        add(0,0,0, 1,0,0,0, 10,256);
        add(1,3,0, 1,0,0,0, 0,768);
        add(1,0,0, 1,0,0,0, 0,768);
        add(1,0,0, 0,1,0,0, 0,768);
        // abort on RUN cycle 5
        for (int i = 1; i <= 4; i++) add(1,0,0, 0,1,0,0, i,768);
        add(0,0,0, 1,0,0,0, 5,768);
        add(0,0,1, 1,0,0,0, 5,768);
        // timeout after exactly 20 RUN cycles
        add(1,0,0, 1,0,0,0, 0,0);
        add(1,0,0, 1,0,0,0, 0,0);
        add(1,0,0, 0,1,0,0, 0,0);
        for (int i = 1; i <= 19; i++) add(1,0,0, 0,1,0,0, i,0);
        add(1,0,0, 0,0,0,1, 20,0);
        add(1,0,0, 0,0,1,1, 20,0);
        add(0,0,0, 1,0,0,1, 20,0);
        // halt coinciding with the timeout cycle counts as a halt
        add(1,2,0, 1,0,0,0, 0,512);
        add(1,0,0, 1,0,0,0, 0,512);
        add(1,0,0, 0,1,0,0, 0,512);
        for (int i = 1; i <= 19; i++) add(1,0,0, 0,1,0,0, i,512);
        add(1,0,1, 0,0,0,0, 20,512);
        add(1,0,0, 0,0,1,0, 20,512);
        add(0,0,0, 1,0,0,0, 20,512);

        reset    = 1'b0;
        req      = 1'b0;
        prog_sel = 2'd0;
        halt_in  = 1'b0;
        #3;
        chk_all(-1, 1,0,0,0, 0,0);
        #1 reset = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            req      = vecs[i].req;
            prog_sel = vecs[i].sel;
            halt_in  = vecs[i].halt;
            tick();
            chk_all(i, 32'(vecs[i].rst), 32'(vecs[i].en), 32'(vecs[i].dn), 32'(vecs[i].tmo),
                    32'(vecs[i].cnt), 32'(vecs[i].addr));
        end

        // async reset between edges during RUN
        req      = 1'b1;
        prog_sel = 2'd1;
        halt_in  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_all(1000, 0,1,0,0, 3,256);
        #2 reset = 1'b0;
        #1;
        chk_all(1001, 1,0,0,0, 0,0);
        req = 1'b0;
        #2 reset = 1'b1;
        tick();
        chk_all(1002, 1,0,0,0, 0,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
